// File: rtl/md5_msg_padder.sv
// MD5 message padder: packs a big-endian byte stream into little-endian 512-bit blocks,
// appends the 0x80 pad byte, zero fill and bit length, and sequences the core handshake.
module md5_msg_padder #(
  parameter int LEN_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         msg_done,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_LEN, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t             state_q;
  logic [31:0]        words_q [16];
  logic [4:0]         idx_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               pad_fin_q, pend_q, need80_q, final_q, skip_q;
  logic               core_init_q, core_next_q, msg_done_q, busy_q;

  logic               beat_s, full_s;
  logic [4:0]         nf_d;
  logic [LEN_W-1:0]   cnt_d;
  logic [63:0]        bitlen_s;

  function automatic logic [31:0] le_word(input logic [31:0] d);
    le_word = {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Keep the first n bytes, place 0x80 right after them, zero the rest.
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    pad_word = 32'h0000_0080;
      3'd1:    pad_word = {16'h0000, 8'h80, d[31:24]};
      3'd2:    pad_word = {8'h00, 8'h80, d[23:16], d[31:24]};
      3'd3:    pad_word = {8'h80, d[15:8], d[23:16], d[31:24]};
      default: pad_word = le_word(d);
    endcase
  endfunction

  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] c);
    bit_len = 64'({c, 3'b000});
  endfunction

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_FILL);
  assign beat_s    = in_valid && in_ready;
  assign full_s    = (in_bytes >= 3'd4);
  assign bitlen_s  = bit_len(cnt_q);
  assign core_init = core_init_q;
  assign core_next = core_next_q;
  assign msg_done  = msg_done_q;
  assign busy      = busy_q;

  // Next byte count and first free word index after the current beat.
  always_comb begin
    nf_d  = idx_q + (full_s ? 5'd2 : 5'd1);
    if (in_last) begin
      cnt_d = cnt_q + LEN_W'(in_bytes);
    end else begin
      cnt_d = cnt_q + LEN_W'(3'd4);
    end
  end

  // Block output is the word buffer, word 0 in the top lane.
  always_comb begin
    core_block = {512{1'b0}};
    for (int k = 0; k < 16; k++) begin
      core_block[511 - 32*k -: 32] = words_q[k];
    end
  end

  // Padder state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < 16; k++) words_q[k] <= 32'h0000_0000;
      idx_q       <= 5'd0;
      cnt_q       <= {LEN_W{1'b0}};
      pad_fin_q   <= 1'b0;
      pend_q      <= 1'b0;
      need80_q    <= 1'b0;
      final_q     <= 1'b0;
      skip_q      <= 1'b0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      msg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      msg_done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_FILL: begin
          if (beat_s) begin
            if (state_q == S_IDLE) begin
              core_init_q <= 1'b1;
              busy_q      <= 1'b1;
            end
            cnt_q <= cnt_d;
            if (!in_last) begin
              words_q[idx_q[3:0]] <= le_word(in_data);
              idx_q <= idx_q + 5'd1;
              if (idx_q == 5'd15) begin
                state_q     <= S_ISSUE;
                core_next_q <= 1'b1;
                final_q     <= 1'b0;
                pend_q      <= 1'b0;
              end else begin
                state_q <= S_FILL;
              end
            end else begin
              words_q[idx_q[3:0]] <= pad_word(in_data, in_bytes);
              // A full last word pushes the pad byte into the next word, possibly the next block.
              if (full_s && (idx_q != 5'd15)) begin
                words_q[idx_q[3:0] + 4'd1] <= 32'h0000_0080;
              end
              need80_q <= full_s && (idx_q == 5'd15);
              idx_q    <= nf_d;
              final_q  <= 1'b0;
              if (nf_d <= 5'd13) begin
                state_q   <= S_PAD;
                pad_fin_q <= 1'b1;
              end else if (nf_d == 5'd14) begin
                state_q <= S_LEN;
              end else if (nf_d == 5'd15) begin
                state_q   <= S_PAD;
                pad_fin_q <= 1'b0;
              end else begin
                state_q     <= S_ISSUE;
                core_next_q <= 1'b1;
                pend_q      <= 1'b1;
              end
            end
          end
        end
        S_PAD: begin
          words_q[idx_q[3:0]] <= need80_q ? 32'h0000_0080 : 32'h0000_0000;
          need80_q <= 1'b0;
          if (pad_fin_q && (idx_q >= 5'd13)) begin
            state_q <= S_LEN;
          end else if (!pad_fin_q && (idx_q >= 5'd15)) begin
            state_q     <= S_ISSUE;
            core_next_q <= 1'b1;
            pend_q      <= 1'b1;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        S_LEN: begin
          words_q[14] <= bitlen_s[31:0];
          words_q[15] <= bitlen_s[63:32];
          final_q     <= 1'b1;
          state_q     <= S_ISSUE;
          core_next_q <= 1'b1;
        end
        S_ISSUE: begin
          skip_q  <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The core's ready output lags core_next by a cycle, so skip one sample.
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (core_ready) begin
            idx_q <= 5'd0;
            if (final_q) begin
              state_q    <= S_DONE;
              msg_done_q <= 1'b1;
            end else if (pend_q) begin
              state_q   <= S_PAD;
              pad_fin_q <= 1'b1;
              pend_q    <= 1'b0;
            end else begin
              state_q <= S_FILL;
            end
          end else begin
            skip_q <= 1'b0;
          end
        end
        S_DONE: begin
          idx_q    <= 5'd0;
          cnt_q    <= {LEN_W{1'b0}};
          busy_q   <= 1'b0;
          final_q  <= 1'b0;
          pend_q   <= 1'b0;
          need80_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Scoreboard bench for md5_msg_padder: directed messages push hand-built expected blocks,
// a negedge monitor plays the MD5 core and compares every block the padder issues.
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         core_init, core_next, core_ready, msg_done, busy;
  logic [511:0] core_block;

  always #5 clk = ~clk;

  md5_msg_padder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .msg_done(msg_done), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, first_cyc = 0, last_beat_cyc = 0, last_next_cyc = 0;
  int init_cnt = 0, next_cnt = 0, done_cnt = 0, lat = 0, core_lat = 4, blk_no = 0;
  logic [7:0]   msg [0:255];
  logic [511:0] exp_q [$];
  logic [511:0] blk, blk2;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_blk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] raw_block(input int b);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) begin
      int p;
      p = 64*b + 4*k;
      r[511 - 32*k -: 32] = {msg[p+3], msg[p+2], msg[p+1], msg[p]};
    end
    return r;
  endfunction

  function automatic logic [511:0] put_word(input logic [511:0] b, input int k, input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511 - 32*k -: 32] = w;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and core model: pops the scoreboard on every core_next.
  initial begin
    core_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (core_init) begin
          init_cnt++;
          check32("init_timing", 32'(cyc), 32'(first_cyc + 1));
          check32("init_next_excl", 32'(core_next), 32'd0);
        end
        if (core_next) begin
          next_cnt++;
          last_next_cyc = cyc;
          check32("ready_low_issue", 32'(in_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check32("unexpected_block", 32'd1, 32'd0);
          end else begin
            check_blk($sformatf("block%0d", blk_no), core_block, exp_q.pop_front());
          end
          blk_no++;
          core_ready = 1'b0;
          lat = core_lat;
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) core_ready = 1'b1;
        end
        if (msg_done) done_cnt++;
      end
    end
  end

  task automatic send_msg(input int len, input bit term);
    int nb;
    bit acc, rdy;
    nb = (len == 0) ? 1 : (len + 3) / 4;
    init_cnt = 0;
    for (int j = 0; j < nb; j++) begin
      logic [31:0] d;
      d = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (4*j + b < len) d[31 - 8*b -: 8] = msg[4*j + b];
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = term && (j == nb - 1);
      in_bytes = in_last ? 3'(len - 4*j) : 3'd4;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        if (t > 0) @(negedge clk);
        rdy = in_ready;
        if (rdy && j == 0) first_cyc = cyc;
        if (rdy) last_beat_cyc = cyc;
        @(posedge clk);
        acc = rdy;
      end
      if (!acc) begin
        check32("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check32("busy_mid", 32'(busy), 32'd1);
  endtask

  task automatic run_msg(input string nm, input int len, input int nblk);
    int n0;
    bit seen;
    n0 = next_cnt;
    send_msg(len, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 600 && !seen; t++) begin
      @(negedge clk);
      if (msg_done) seen = 1'b1;
    end
    check32({nm, "_done"}, 32'(seen), 32'd1);
    check32({nm, "_nblocks"}, 32'(next_cnt - n0), 32'(nblk));
    check32({nm, "_init_once"}, 32'(init_cnt), 32'd1);
    check32({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    if (nblk == 1) begin
      check32({nm, "_latency"}, 32'(last_next_cyc - last_beat_cyc <= 16), 32'd1);
    end
    @(negedge clk);
    check32({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check32({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n0, d0;
    reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; in_bytes = 3'd0;
    repeat (3) @(negedge clk);
    check32("rst_in_ready", 32'(in_ready), 32'd1);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_pulses", 32'({core_init, core_next, msg_done}), 32'd0);
    check_blk("rst_block", core_block, 512'd0);
    reset = 1'b0;

    // "abc": one block, hand-built
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    blk = put_word(put_word(512'd0, 0, 32'h80636261), 14, 32'h00000018);
    exp_q.push_back(blk);
    run_msg("abc", 3, 1);

    // empty message
    exp_q.push_back(put_word(512'd0, 0, 32'h00000080));
    run_msg("empty", 0, 1);

    for (int i = 0; i < 256; i++) msg[i] = 8'(i + 1);

    // 52 bytes: pad byte lands in word 13, length fits the same block
    blk = put_word(put_word(put_word(raw_block(0), 13, 32'h80), 14, 32'h1A0), 15, 32'h0);
    exp_q.push_back(blk);
    run_msg("len52", 52, 1);

    // 56 bytes: second block is zeros plus length
    exp_q.push_back(put_word(put_word(raw_block(0), 14, 32'h80), 15, 32'h0));
    exp_q.push_back(put_word(512'd0, 14, 32'h1C0));
    run_msg("len56", 56, 2);

    // 57 bytes: partial tail word 14
    exp_q.push_back(put_word(put_word(raw_block(0), 14, 32'h00008039), 15, 32'h0));
    exp_q.push_back(put_word(512'd0, 14, 32'h1C8));
    run_msg("len57", 57, 2);

    // 60 bytes: pad byte fills word 15 exactly
    exp_q.push_back(put_word(raw_block(0), 15, 32'h80));
    exp_q.push_back(put_word(512'd0, 14, 32'h1E0));
    run_msg("len60", 60, 2);

    // 64 bytes: pad byte spills into word 0 of block 2
    exp_q.push_back(raw_block(0));
    exp_q.push_back(put_word(put_word(512'd0, 0, 32'h80), 14, 32'h200));
    run_msg("len64", 64, 2);

    // 128 bytes with continuous in_valid and a slower core
    core_lat = 7;
    exp_q.push_back(raw_block(0));
    exp_q.push_back(raw_block(1));
    exp_q.push_back(put_word(put_word(512'd0, 0, 32'h80), 14, 32'h400));
    run_msg("len128", 128, 3);
    core_lat = 4;

    // reset while waiting on the core
    n0 = next_cnt;
    exp_q.push_back(raw_block(0));
    send_msg(64, 1'b0);
    #1;
    for (int t = 0; t < 100 && next_cnt == n0; t++) begin
      @(negedge clk);
      #1;
    end
    check32("rst_wait_issue", 32'(next_cnt - n0), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    check32("rstw_in_ready", 32'(in_ready), 32'd1);
    check32("rstw_busy", 32'(busy), 32'd0);
    check32("rstw_done", 32'(msg_done), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check32("rstw_no_done", 32'(done_cnt - d0), 32'd0);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    exp_q.push_back(put_word(put_word(512'd0, 0, 32'h80636261), 14, 32'h00000018));
    run_msg("abc_after_rst", 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
